// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined LEGv8-subset CPU.
// These are the instruction geometry, the bubble encoding and the IF/ID record layout.
package cpu_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 11;
    localparam int PC_W     = 64;

    // Opcode 11'h000 decodes to no register writes and no memory access.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_pipe_reg.sv
// Generic enabled pipeline register with synchronous reset and a synchronous clear-to-value.
// Priority is reset > clr > en.
module pipe_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage plus IF/ID register: owns the PC, addresses instruction memory, latches the fetched word.
// Build option: define IF_FLUSH_EN to squash the wrong-path fetch on redirect (default is delay slot).
module instr_fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                if_id_valid,
    output logic [10:0]         opcode
);

    import cpu_pkg::*;

    localparam int                IFID_W    = INSTR_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PC_RST    = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [IFID_W-1:0] IFID_RST  = {INSTR_W'(NOP_INSTR), {ADDR_W{1'b0}}, 1'b0};

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic              adv;
    logic              ifid_clr;
    logic [IFID_W-1:0] ifid_clr_val;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_p1;
    logic              unused_redirect_lsbs;

    // A redirect always advances, even under stall, so the target is never lost.
    assign adv    = ~stall | redirect;
    assign pc_nxt = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : pc_p0 + ADDR_W'(4);
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ---- IF: program counter ----
    pipe_reg #(
        .W       (ADDR_W),
        .RST_VAL (PC_RST)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (adv),
        .clr     (1'b0),
        .clr_val ({ADDR_W{1'b0}}),
        .d       (pc_nxt),
        .q       (pc_p0)
    );

    assign imem_addr = pc_p0;
    assign ifid_d    = {imem_rdata, pc_p0, 1'b1};

`ifdef IF_FLUSH_EN
    // The word fetched alongside a taken branch is wrong-path: replace it with a bubble.
    assign ifid_clr     = redirect;
    assign ifid_clr_val = {INSTR_W'(NOP_INSTR), pc_p0, 1'b0};
`else
    assign ifid_clr     = 1'b0;
    assign ifid_clr_val = '0;
`endif

    // ---- IF/ID boundary ----
    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (adv),
        .clr     (ifid_clr),
        .clr_val (ifid_clr_val),
        .d       (ifid_d),
        .q       (ifid_p1)
    );

    assign {if_id_instr, if_id_pc, if_id_valid} = ifid_p1;
    assign opcode = if_id_instr[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: vector table plus hand-written reset/redirect corner sequences.
module tb_instr_fetch_stage;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
`ifdef IF_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic               if_id_valid;
    logic [10:0]        opcode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .opcode      (opcode)
    );

    // Combinational instruction memory: one known word at 8, an address-tagged pattern elsewhere.
    function automatic logic [INSTR_W-1:0] mem(input logic [ADDR_W-1:0] a);
        if (a == 64'd8) return 32'h9100_0421;
        return 32'hD000_0000 ^ a[31:0];
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                             input logic e_valid);
        logic [31:0] e_instr;
        e_instr = e_valid ? mem(e_ifpc) : 32'h0;
        chk({tag, ".imem_addr"},   imem_addr,   e_pc);
        chk({tag, ".if_id_pc"},    if_id_pc,    e_ifpc);
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(e_valid));
        chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(e_instr));
        chk({tag, ".opcode"},      64'(opcode),  64'(e_instr[31:21]));
    endtask

    typedef struct {
        string       name;
        logic        stall;
        logic        redirect;
        logic [63:0] rpc;
        logic [63:0] e_pc;
        logic [63:0] e_ifpc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Starts from pc=0 after reset; each row is the state one edge after applying its inputs.
        vecs.push_back('{"seq0",     0, 0, 64'h0,  64'd4,  64'd0,  1'b1});
        vecs.push_back('{"seq1",     0, 0, 64'h0,  64'd8,  64'd4,  1'b1});
        vecs.push_back('{"seq2",     0, 0, 64'h0,  64'd12, 64'd8,  1'b1});
        vecs.push_back('{"stall0",   1, 0, 64'h0,  64'd12, 64'd8,  1'b1});
        vecs.push_back('{"stall1",   1, 0, 64'h0,  64'd12, 64'd8,  1'b1});
        vecs.push_back('{"stall2",   1, 0, 64'h0,  64'd12, 64'd8,  1'b1});
        vecs.push_back('{"unstall",  0, 0, 64'h0,  64'd16, 64'd12, 1'b1});
        vecs.push_back('{"seq3",     0, 0, 64'h0,  64'd20, 64'd16, 1'b1});
        vecs.push_back('{"redir40",  0, 1, 64'h40, 64'h40, 64'd20, !FLUSH});
        vecs.push_back('{"tgt40",    0, 0, 64'h0,  64'h44, 64'h40, 1'b1});
        vecs.push_back('{"redirstl", 1, 1, 64'h83, 64'h80, 64'h44, !FLUSH});
        vecs.push_back('{"b2b_a",    0, 1, 64'h100, 64'h100, 64'h80,  !FLUSH});
        vecs.push_back('{"b2b_b",    0, 1, 64'h202, 64'h200, 64'h100, !FLUSH});
        vecs.push_back('{"redirtop", 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h200, !FLUSH});
        vecs.push_back('{"wrap",     0, 0, 64'h0,  64'h0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b1});
        vecs.push_back('{"postwrap", 0, 0, 64'h0,  64'h4,  64'h0, 1'b1});

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        chk("rst.imem_addr",   imem_addr, 64'h0);
        chk("rst.if_id_valid", 64'(if_id_valid), 64'h0);
        chk("rst.opcode",      64'(opcode), 64'h0);
        chk("rst.if_id_instr", 64'(if_id_instr), 64'h0);
        chk("rst.if_id_pc",    if_id_pc, 64'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            step();
            chk_state(vecs[i].name, vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_valid);
        end
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        chk("seq2.opcode_known", 64'(mem(64'd8) >> 21), 64'h488);

        // Reset during a stall overrides the hold.
        step();
        stall = 1'b1; reset = 1'b1;
        step();
        chk("rststall.imem_addr",   imem_addr, 64'h0);
        chk("rststall.if_id_valid", 64'(if_id_valid), 64'h0);
        chk("rststall.if_id_instr", 64'(if_id_instr), 64'h0);

        // Reset during a redirect overrides the target.
        stall = 1'b0; redirect = 1'b1; redirect_pc = 64'h300;
        step();
        chk("rstredir.imem_addr", imem_addr, 64'h0);
        chk("rstredir.if_id_pc",  if_id_pc, 64'h0);

        // Valid rises on the first normal edge after release.
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        chk_state("release", 64'd4, 64'd0, 1'b1);

        // Stall right after reset keeps the bubble.
        reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b1;
        step();
        chk("rel_stall.imem_addr",   imem_addr, 64'h0);
        chk("rel_stall.if_id_valid", 64'(if_id_valid), 64'h0);
        stall = 1'b0;
        step();
        chk_state("rel_go", 64'd4, 64'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
